// File: rtl/mul_booth_seq.sv
// ============================================================================
//  Module   : mul_booth_seq
//  Purpose  : Multi-cycle sequencer for a 32x32 radix-4 Booth partial-product
//             generator; sums the partial products and applies the
//             unsigned-operand correction for MUL/MULH/MULHSU/MULHU.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_booth_seq #(
  parameter int PP_PER_CYCLE = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     in_op,
  input  logic [31:0]    in_a,
  input  logic [31:0]    in_b,
  input  logic           flush,
  output logic [31:0]    pp_a,
  output logic [31:0]    pp_b,
  input  logic [1023:0]  pp_flat,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [31:0]    out_result,
  output logic           busy
);

  localparam int         c_NGRP     = 16 / PP_PER_CYCLE;
  localparam logic [3:0] c_GRP_LAST = 4'(c_NGRP - 1);
  localparam logic [1:0] c_OP_MUL    = 2'd0;
  localparam logic [1:0] c_OP_MULHSU = 2'd2;
  localparam logic [1:0] c_OP_MULHU  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_CORR  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_op;
  logic [31:0] r_pp_a;
  logic [31:0] r_pp_b;
  logic [63:0] r_acc;
  logic [3:0]  r_grp;
  logic [63:0] w_grp_sum;
  logic [63:0] w_corr;
  logic        w_accept;

  // Partial products of the current group, selected by grp.
  always_comb begin
    logic [3:0] idx;
    w_grp_sum = '0;
    idx       = '0;
    for (int j = 0; j < PP_PER_CYCLE; j++) begin
      idx       = 4'(int'(r_grp) * PP_PER_CYCLE + j);
      w_grp_sum = w_grp_sum + pp_flat[{idx, 6'd0} +: 64];
    end
  end

  // The generator treats both operands as signed; add back 2^32 * other
  // operand for each operand whose top bit should read as unsigned.
  always_comb begin
    w_corr = '0;
    case (r_op)
      c_OP_MULHSU: w_corr = r_pp_b[31] ? {r_pp_a, 32'b0} : 64'd0;
      c_OP_MULHU:  w_corr = (r_pp_a[31] ? {r_pp_b, 32'b0} : 64'd0)
                          + (r_pp_b[31] ? {r_pp_a, 32'b0} : 64'd0);
      default:     w_corr = '0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_ACCUM;
      S_ACCUM: if (r_grp == c_GRP_LAST) w_next = S_CORR;
      S_CORR:  w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  assign w_accept = (r_state == S_IDLE) && in_valid && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_pp_a  <= '0;
      r_pp_b  <= '0;
      r_acc   <= '0;
      r_grp   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op   <= in_op;
        r_pp_a <= in_a;
        r_pp_b <= in_b;
        r_acc  <= '0;
        r_grp  <= '0;
      end else if (r_state == S_ACCUM) begin
        r_acc <= r_acc + w_grp_sum;
        r_grp <= r_grp + 4'd1;
      end else if (r_state == S_CORR) begin
        r_acc <= r_acc + w_corr;
      end
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);
  assign pp_a       = r_pp_a;
  assign pp_b       = r_pp_b;
  assign out_result = (r_op == c_OP_MUL) ? r_acc[31:0] : r_acc[63:32];

endmodule

`default_nettype wire
